// File: rtl/ofs_plat_ccip_traffic_mon_pkg.sv
// Shared types for the CCI-P traffic monitor: minimal CCI-P channel structs,
// error-bit indices, watchdog states and the cache-line decode helper.
package ofs_plat_ccip_traffic_mon_pkg;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic       valid;
    logic [1:0] cl_len;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic         valid;
    logic         sop;
    logic [1:0]   cl_len;
    t_ccip_c1_req req_type;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic mmioRdValid;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  typedef struct packed {
    logic         rspValid;
    t_ccip_c0_rsp resp_type;
    logic         mmioRdValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic         rspValid;
    t_ccip_c1_rsp resp_type;
    logic         format;
    logic [1:0]   cl_num;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  localparam int unsigned ERR_RD_UNDERFLOW   = 0;
  localparam int unsigned ERR_WR_UNDERFLOW   = 1;
  localparam int unsigned ERR_OVERFLOW       = 2;
  localparam int unsigned ERR_MMIO_TIMEOUT   = 3;
  localparam int unsigned ERR_MMIO_UNDERFLOW = 4;

  typedef logic [4:0] t_ccip_mon_err;

  typedef enum logic [1:0] {IDLE, WAIT, EXPIRED} t_mmio_wd_state;

  // cl_len encodes 1/2/4 lines as 0/1/3
  function automatic logic [2:0] ccip_lines(input logic [1:0] cl_len);
    return {1'b0, cl_len} + 3'd1;
  endfunction

endpackage

// File: rtl/ofs_plat_ccip_mon_sat_counter.sv
// Up/down outstanding counter: net update, clamps to 0 on underflow and to
// all-ones above range; flags underflow and values above LIMIT.
module ofs_plat_ccip_mon_sat_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned LIMIT = 512
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       inc,
  input  logic [2:0]       dec,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             overflow
);

  localparam int unsigned EW = WIDTH + 3;
  localparam logic [EW-1:0] LIMIT_EXT = EW'(LIMIT);
  localparam logic [EW-1:0] MAX_EXT   = {3'b000, {WIDTH{1'b1}}};

  logic [EW-1:0]    up;
  logic [EW-1:0]    dn;
  logic [EW-1:0]    sum;
  logic [WIDTH-1:0] next;

  always_comb begin
    up        = {3'b000, count} + EW'(inc);
    dn        = EW'(dec);
    underflow = dn > up;
    sum       = up - dn;
    overflow  = !underflow && (sum > LIMIT_EXT);
    if (underflow)          next = '0;
    else if (sum > MAX_EXT) next = '1;
    else                    next = sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count <= '0;
    else          count <= next;
  end

endmodule

// File: rtl/ofs_plat_host_ccip_traffic_monitor.sv
// Passive CCI-P monitor: outstanding line/fence/MMIO tracking, MMIO watchdog,
// sticky error vector. OFS_PLAT_CCIP_TRAFFIC_MON_STATS_EN adds line statistics.
module ofs_plat_host_ccip_traffic_monitor
  import ofs_plat_ccip_traffic_mon_pkg::*;
#(
  parameter int unsigned CNT_WIDTH       = 10,
  parameter int unsigned MAX_OUTSTANDING = 512,
  parameter int unsigned MMIO_CNT_WIDTH  = 4,
  parameter int unsigned MMIO_TIMEOUT    = 4096,
  parameter int unsigned STAT_WIDTH      = 48
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  t_if_ccip_Tx               sTx,
  input  t_if_ccip_Rx               sRx,
  input  logic                      err_clear,
  output logic [CNT_WIDTH-1:0]      rd_outstanding,
  output logic [CNT_WIDTH-1:0]      wr_outstanding,
  output logic [CNT_WIDTH-1:0]      fence_outstanding,
  output logic [MMIO_CNT_WIDTH-1:0] mmio_rd_outstanding,
`ifdef OFS_PLAT_CCIP_TRAFFIC_MON_STATS_EN
  output logic [STAT_WIDTH-1:0]     stat_rd_req_lines,
  output logic [STAT_WIDTH-1:0]     stat_rd_rsp_lines,
  output logic [STAT_WIDTH-1:0]     stat_wr_req_lines,
  output logic [STAT_WIDTH-1:0]     stat_wr_rsp_lines,
`endif
  output logic [4:0]                err_vec,
  output logic                      error
);

  localparam int unsigned TW = $clog2(MMIO_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(MMIO_TIMEOUT);
  localparam int unsigned MW = MMIO_CNT_WIDTH + 1;

  logic [2:0] rd_inc, rd_dec, wr_inc, wr_dec, fence_inc, fence_dec, mmio_inc, mmio_dec;
  logic       wr_req, wr_rsp;
  logic       rd_unf, rd_ovf, wr_unf, wr_ovf, fence_unf, fence_ovf, mmio_unf, mmio_ovf;

  always_comb begin
    wr_req = sTx.c1.valid && sTx.c1.sop &&
             (sTx.c1.req_type inside {eREQ_WRLINE_I, eREQ_WRLINE_M, eREQ_WRPUSH_I});
    wr_rsp = sRx.c1.rspValid && (sRx.c1.resp_type == eRSP_WRLINE);
    rd_inc = sTx.c0.valid ? ccip_lines(sTx.c0.cl_len) : 3'd0;
    rd_dec = {2'b00, sRx.c0.rspValid && (sRx.c0.resp_type == eRSP_RDLINE)};
    wr_inc = wr_req ? ccip_lines(sTx.c1.cl_len) : 3'd0;
    wr_dec = 3'd0;
    if (wr_rsp) wr_dec = sRx.c1.format ? ccip_lines(sRx.c1.cl_num) : 3'd1;
    fence_inc = {2'b00, sTx.c1.valid && (sTx.c1.req_type == eREQ_WRFENCE)};
    fence_dec = {2'b00, sRx.c1.rspValid && (sRx.c1.resp_type == eRSP_WRFENCE)};
    mmio_inc  = {2'b00, sRx.c0.mmioRdValid};
    mmio_dec  = {2'b00, sTx.c2.mmioRdValid};
  end

  ofs_plat_ccip_mon_sat_counter #(.WIDTH(CNT_WIDTH), .LIMIT(MAX_OUTSTANDING)) rd_cnt (
    .clk(clk), .reset_n(reset_n), .inc(rd_inc), .dec(rd_dec),
    .count(rd_outstanding), .underflow(rd_unf), .overflow(rd_ovf));

  ofs_plat_ccip_mon_sat_counter #(.WIDTH(CNT_WIDTH), .LIMIT(MAX_OUTSTANDING)) wr_cnt (
    .clk(clk), .reset_n(reset_n), .inc(wr_inc), .dec(wr_dec),
    .count(wr_outstanding), .underflow(wr_unf), .overflow(wr_ovf));

  ofs_plat_ccip_mon_sat_counter #(.WIDTH(CNT_WIDTH), .LIMIT(MAX_OUTSTANDING)) fence_cnt (
    .clk(clk), .reset_n(reset_n), .inc(fence_inc), .dec(fence_dec),
    .count(fence_outstanding), .underflow(fence_unf), .overflow(fence_ovf));

  // MMIO overflow means "would wrap", so the limit is the counter's own maximum
  ofs_plat_ccip_mon_sat_counter #(.WIDTH(MMIO_CNT_WIDTH), .LIMIT((1 << MMIO_CNT_WIDTH) - 1)) mmio_cnt (
    .clk(clk), .reset_n(reset_n), .inc(mmio_inc), .dec(mmio_dec),
    .count(mmio_rd_outstanding), .underflow(mmio_unf), .overflow(mmio_ovf));

  t_mmio_wd_state state, state_next;
  logic [TW-1:0]  timer, timer_next;
  logic           timeout;
  logic           mmio_idle_next;

  always_comb begin
    mmio_idle_next = ({1'b0, mmio_rd_outstanding} + MW'(mmio_inc)) <= MW'(mmio_dec);
    state_next     = state;
    timer_next     = timer;
    timeout        = 1'b0;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (!mmio_idle_next) state_next = WAIT;
      end
      WAIT: begin
        if (mmio_idle_next) begin
          state_next = IDLE;
          timer_next = '0;
        end else if (sTx.c2.mmioRdValid) begin
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
          if (timer_next == TIMEOUT_VAL) begin
            timeout    = 1'b1;
            state_next = EXPIRED;
          end
        end
      end
      EXPIRED: begin
        if (mmio_idle_next) begin
          state_next = IDLE;
          timer_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  t_ccip_mon_err new_err;

  always_comb begin
    new_err                     = '0;
    new_err[ERR_RD_UNDERFLOW]   = rd_unf;
    new_err[ERR_WR_UNDERFLOW]   = wr_unf | fence_unf;
    new_err[ERR_OVERFLOW]       = rd_ovf | wr_ovf | fence_ovf | mmio_ovf;
    new_err[ERR_MMIO_TIMEOUT]   = timeout;
    new_err[ERR_MMIO_UNDERFLOW] = mmio_unf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      timer   <= '0;
      err_vec <= '0;
      error   <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      err_vec <= (err_clear ? '0 : err_vec) | new_err;
      error   <= |err_vec;
    end
  end

`ifdef OFS_PLAT_CCIP_TRAFFIC_MON_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd_req_lines <= '0;
      stat_rd_rsp_lines <= '0;
      stat_wr_req_lines <= '0;
      stat_wr_rsp_lines <= '0;
    end else begin
      stat_rd_req_lines <= stat_rd_req_lines + STAT_WIDTH'(rd_inc);
      stat_rd_rsp_lines <= stat_rd_rsp_lines + STAT_WIDTH'(rd_dec);
      stat_wr_req_lines <= stat_wr_req_lines + STAT_WIDTH'(wr_inc);
      stat_wr_rsp_lines <= stat_wr_rsp_lines + STAT_WIDTH'(wr_dec);
    end
  end
`endif

endmodule
